// File: rtl/maxpool_relu_stream_if.sv
// Handshake bundle for the max-pool stream: sample input side plus pooled-result output side.
// The slave modport is the pooling unit; the master modport is its surrounding datapath.
interface maxpool_relu_stream_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  out_count;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count
    );
endinterface

// File: rtl/maxpool_relu_stream.sv
// Streaming max-pool: folds up to WINDOW samples (or fewer, ended by in_last) into one
// value, optionally ReLU-clamped, with registered valid/ready output.
module maxpool_relu_stream #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned WINDOW = 4,
    parameter int unsigned CNT_W  = $clog2(WINDOW + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   relu_en,
    maxpool_relu_stream_if.slave   bus
);

    typedef enum logic {EMPTY, ACCUM} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              mode_q, mode_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0]  out_count_q, out_count_d;

    logic              in_ready_c;
    logic              accept_c;
    logic              cur_mode_c;
    logic [DATA_W-1:0] fx_c;
    logic [DATA_W-1:0] new_acc_c;
    logic [CNT_W-1:0]  new_cnt_c;
    logic              close_c;

    // ReLU clamps any negative sample (including the most negative value) to zero.
    function automatic logic [DATA_W-1:0] f_val(input logic [DATA_W-1:0] x, input logic relu);
        if (relu && x[DATA_W-1]) return '0;
        return x;
    endfunction

    // In ReLU mode both operands are non-negative, so magnitude of the low bits decides.
    function automatic logic greater(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                     input logic relu);
        if (relu) return a[DATA_W-2:0] > b[DATA_W-2:0];
        return $signed(a) > $signed(b);
    endfunction

    assign in_ready_c = !out_valid_q || bus.out_ready;
    assign accept_c   = bus.in_valid && in_ready_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            cnt_q       <= '0;
            acc_q       <= '0;
            mode_q      <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
        end
    end

    // Window fold and output handshake.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mode_d      = mode_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        cur_mode_c  = mode_q;
        fx_c        = '0;
        new_acc_c   = acc_q;
        new_cnt_c   = cnt_q;
        close_c     = 1'b0;

        if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

        if (accept_c) begin
            unique case (state_q)
                EMPTY: begin
                    cur_mode_c = relu_en;
                    mode_d     = relu_en;
                    fx_c       = f_val(bus.in_data, relu_en);
                    new_acc_c  = fx_c;
                    new_cnt_c  = CNT_W'(1);
                end
                ACCUM: begin
                    cur_mode_c = mode_q;
                    fx_c       = f_val(bus.in_data, mode_q);
                    new_acc_c  = greater(fx_c, acc_q, cur_mode_c) ? fx_c : acc_q;
                    new_cnt_c  = CNT_W'(cnt_q + CNT_W'(1));
                end
                default: ;
            endcase

            close_c = (new_cnt_c == CNT_W'(WINDOW)) || bus.in_last;

            if (close_c) begin
                out_valid_d = 1'b1;
                out_data_d  = new_acc_c;
                out_count_d = new_cnt_c;
                acc_d       = '0;
                cnt_d       = '0;
                state_d     = EMPTY;
            end else begin
                acc_d   = new_acc_c;
                cnt_d   = new_cnt_c;
                state_d = ACCUM;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_count = out_count_q;

endmodule

// File: tb/tb_maxpool_relu_stream.sv
// Directed bench for maxpool_relu_stream: expected results are queued at stimulus time
// and a separate monitor pops and compares them on each output handshake.
module tb_maxpool_relu_stream;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned WINDOW = 4;
    localparam int unsigned CNT_W  = $clog2(WINDOW + 1);

    logic clk;
    logic rst_n;
    logic relu_en;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] exp_d[$];
    logic [CNT_W-1:0]  exp_c[$];

    maxpool_relu_stream_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    maxpool_relu_stream #(.DATA_W(DATA_W), .WINDOW(WINDOW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .relu_en (relu_en),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_res(input logic [DATA_W-1:0] d, input logic [CNT_W-1:0] c);
        exp_d.push_back(d);
        exp_c.push_back(c);
    endtask

    // Present one sample and return #1 after the edge on which it is accepted.
    task automatic send(input logic [DATA_W-1:0] d, input logic l);
        bit ok;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stuck 0 for sample 0x%08h", d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // Handshake completes on the following rising edge; inputs are stable until then.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            checks++;
            if (exp_d.size() == 0) begin
                errors++;
                $display("FAIL mon_unexpected: got data 0x%08h count %0d, expected no output",
                         bus.out_data, bus.out_count);
            end else begin
                logic [DATA_W-1:0] ed;
                logic [CNT_W-1:0]  ec;
                ed = exp_d.pop_front();
                ec = exp_c.pop_front();
                if (bus.out_data !== ed || bus.out_count !== ec) begin
                    errors++;
                    $display("FAIL mon_result: got data 0x%08h count %0d, expected data 0x%08h count %0d",
                             bus.out_data, bus.out_count, ed, ec);
                end
            end
        end
    end

    initial begin
        rst_n         = 1'b0;
        relu_en       = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(bus.out_valid), 32'h0);
        chk("reset_out_data", bus.out_data, 32'h0);
        chk("reset_out_count", 32'(bus.out_count), 32'h0);
        chk("reset_in_ready", 32'(bus.in_ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: ReLU max with a negative sample clamped, plus latency.
        relu_en = 1'b1;
        expect_res(32'h0000000A, CNT_W'(4));
        send(32'h00000005, 1'b0);
        send(32'h80000009, 1'b0);
        send(32'h00000003, 1'b0);
        chk("t1_valid_before_close", 32'(bus.out_valid), 32'h0);
        send(32'h0000000A, 1'b0);
        chk("t1_valid_after_close", 32'(bus.out_valid), 32'h1);
        chk("t1_data_after_close", bus.out_data, 32'h0000000A);

        // 2: all negative in ReLU mode pools to zero.
        expect_res(32'h00000000, CNT_W'(4));
        send(32'hFFFFFFFF, 1'b0);
        send(32'h80000000, 1'b0);
        send(32'h80000001, 1'b0);
        send(32'hFFFFFFF0, 1'b0);

        // 3: signed max, then a mid-window mode flip that must be ignored.
        relu_en = 1'b0;
        expect_res(32'hFFFFFFFE, CNT_W'(4));
        send(32'hFFFFFFF9, 1'b0);
        send(32'hFFFFFFFE, 1'b0);
        send(32'hFFFFFFF7, 1'b0);
        send(32'hFFFFFFFD, 1'b0);
        expect_res(32'hFFFFFFFC, CNT_W'(4));
        send(32'hFFFFFFF0, 1'b0);
        send(32'hFFFFFFF8, 1'b0);
        relu_en = 1'b1;
        send(32'hFFFFFFFC, 1'b0);
        send(32'h80000000, 1'b0);

        // 4: short window via in_last, then a full window with no carry-over.
        expect_res(32'h00000008, CNT_W'(2));
        send(32'h00000003, 1'b0);
        send(32'h00000008, 1'b1);
        expect_res(32'h00000002, CNT_W'(4));
        send(32'h00000001, 1'b0);
        send(32'h00000002, 1'b0);
        send(32'h00000001, 1'b0);
        send(32'h00000000, 1'b0);
        idle(2);

        // 5: backpressure hold, then handshake together with a single-sample close.
        bus.out_ready = 1'b0;
        expect_res(32'h00000044, CNT_W'(4));
        send(32'h00000011, 1'b0);
        send(32'h00000022, 1'b0);
        send(32'h00000033, 1'b0);
        send(32'h00000044, 1'b0);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t5_hold_valid", 32'(bus.out_valid), 32'h1);
            chk("t5_hold_in_ready", 32'(bus.in_ready), 32'h0);
            chk("t5_hold_data", bus.out_data, 32'h00000044);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        expect_res(32'h00000099, CNT_W'(1));
        send(32'h00000099, 1'b1);
        chk("t5_reload_valid", 32'(bus.out_valid), 32'h1);
        chk("t5_reload_data", bus.out_data, 32'h00000099);
        chk("t5_reload_count", 32'(bus.out_count), 32'h1);
        idle(3);

        // 6: asynchronous reset mid-window discards the partial window.
        send(32'h00000050, 1'b0);
        send(32'h00000060, 1'b0);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("t6_rst_out_data", bus.out_data, 32'h0);
        chk("t6_rst_out_count", 32'(bus.out_count), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        expect_res(32'h00000004, CNT_W'(4));
        send(32'h00000001, 1'b0);
        send(32'h00000002, 1'b0);
        send(32'h00000003, 1'b0);
        send(32'h00000004, 1'b0);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;

        for (int n = 0; n < 100; n++) begin
            if (exp_d.size() == 0 && !bus.out_valid) break;
            @(posedge clk);
            #1;
        end
        checks++;
        if (exp_d.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, expected 0", exp_d.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/maxpool_relu_stream.md
Name: maxpool_relu_stream

Overview:
- Streaming max-pool unit for the CNN datapath, generalising the two-input ReLU/max comparator.
- Reduces each window of up to WINDOW samples to a single value, with optional ReLU clamp per window.
- Valid/ready handshake on both input and output sides.
- Sits between the conv accumulator output and the feature-map writeback.

Parameters:
- DATA_W, 32, sample width; MSB is the sign bit.
- WINDOW, 4, samples per pool window; legal range >= 2.
- CNT_W, $clog2(WINDOW+1), width of the window-count output.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- relu_en  in  1  1 = ReLU+max mode; 0 = signed two's-complement max.
- in_valid  in  1  input sample valid.
- in_ready  out  1  input can be accepted.
- in_data  in  DATA_W  input sample.
- in_last  in  1  marks the final sample of a short window.
- out_valid  out  1  pooled result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  DATA_W  pooled result.
- out_count  out  CNT_W  number of samples folded into out_data.

Behaviour:
- Reset: asynchronous on rst_n low.
  - out_valid=0, out_data=0, out_count=0.
  - Sample counter=0, accumulator=0, latched mode=1.
  - Any partial window is discarded.
- Accept: a sample is accepted on a cycle with in_valid && in_ready.
- in_ready = !out_valid || out_ready. Registered-output stall only; no combinational path from in_valid or in_last.
- States:
  - EMPTY (counter=0): the first accepted sample latches relu_en for the whole window and loads the accumulator with f(in_data). Go to ACCUM.
  - ACCUM: each accepted sample sets acc = max(acc, f(in_data)) and increments the counter.
  - A window closes on the accepted sample that brings the count to WINDOW, or on any accepted sample with in_last=1.
  - On close: the final max goes to out_data, the count to out_count, and out_valid=1 on the next edge. Counter returns to 0 (EMPTY).
- Value function:
  - ReLU mode: f(x) = x[DATA_W-1] ? 0 : x, so 0x80000000 maps to 0. Compare by unsigned magnitude of the low DATA_W-1 bits.
  - Signed mode: f(x) = x; compare as two's complement.
- relu_en changes mid-window are ignored until the next EMPTY->ACCUM transition.
- Latency: out_valid rises exactly 1 cycle after the closing sample is accepted. Back-to-back windows are sustained at 1 sample/cycle while out_ready=1.
- Output handshake: the result is held stable (data, count, valid) until out_valid && out_ready.
  - If the handshake and a new closing sample happen in the same cycle, out_data/out_count reload and out_valid stays 1.
  - If the handshake happens with no closing sample, out_valid=0 on the next edge.
- in_last while in EMPTY: single-sample window, out_count=1.
- in_last on the WINDOW-th sample: one close only, out_count=WINDOW.
- in_valid=0 cycles inside a window: no state change and no timeout.
- Counter never exceeds WINDOW; no wrap.

Test Plan (DATA_W=32, WINDOW=4):
1. ReLU mode, out_ready=1; feed 0x00000005, 0x80000009, 0x00000003, 0x0000000A on consecutive cycles.
   - out_valid=1 the cycle after the 4th sample.
   - out_data=0x0000000A, out_count=4.
2. ReLU mode; feed 0xFFFFFFFF, 0x80000000, 0x80000001, 0xFFFFFFF0.
   - out_data=0x00000000, out_count=4.
3. Signed mode; feed 0xFFFFFFF9, 0xFFFFFFFE, 0xFFFFFFF7, 0xFFFFFFFD.
   - out_data=0xFFFFFFFE.
   - Then flip relu_en to 1 after the 2nd sample of the next window: that window still computes a signed max.
4. Feed 3, then 8 with in_last=1.
   - out_data=8, out_count=2.
   - The next 4 samples 1, 2, 1, 0 give out_data=2, out_count=4. No carry-over of 8.
5. Backpressure: complete one window with out_ready=0.
   - in_ready=0 while out_valid=1.
   - out_data stays stable for 10 cycles.
   - Raise out_ready together with a new closing sample: out_valid stays 1 and the new result loads. No sample lost or duplicated.
6. Accept 2 samples (0x00000050, 0x00000060), then pulse rst_n low mid-cycle.
   - Outputs clear immediately.
   - After release, samples 1, 2, 3, 4 give out_data=4, out_count=4.
